// File: rtl/mem_stage_pkg.sv
// Shared widths, load_op encodings and bus layouts for the MEM pipeline stage.
// Bus field order matches the EX->MEM and MEM->WB packing used across the pipeline.
package mem_stage_pkg;

    localparam int to_MEM_data_width = 75;
    localparam int to_WB_data_width  = 70;
    localparam int forwrd_data_width = 37;

    localparam logic [2:0] LOAD_W  = 3'b000;
    localparam logic [2:0] LOAD_B  = 3'b001;
    localparam logic [2:0] LOAD_BU = 3'b101;
    localparam logic [2:0] LOAD_H  = 3'b010;
    localparam logic [2:0] LOAD_HU = 3'b110;

    typedef enum logic [1:0] {
        MEM_EMPTY = 2'd0,
        MEM_WAIT  = 2'd1,
        MEM_HAVE  = 2'd2
    } mem_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic        gr_we;
        logic        res_from_mem;
        logic [2:0]  load_op;
        logic        mem_req;
    } ex_mem_bus_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic        gr_we;
    } mem_wb_bus_t;

endpackage

// File: rtl/mem_stage_if.sv
// Handshake, payload, SRAM-response and forwarding signals around the MEM stage.
// The master modport is the MEM stage itself; slave is the surrounding pipeline.
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic                          EX_to_MEM_valid;
    logic [to_MEM_data_width-1:0]  to_MEM_data;
    logic                          MEM_allow_in;
    logic                          data_sram_data_ok;
    logic [31:0]                   data_sram_rdata;
    logic                          WB_allow_in;
    logic                          MEM_to_WB_valid;
    logic [to_WB_data_width-1:0]   to_WB_data;
    logic [forwrd_data_width-1:0]  MEM_forward;
    logic                          MEM_load_blk;

    modport master (
        input  EX_to_MEM_valid, to_MEM_data, data_sram_data_ok, data_sram_rdata, WB_allow_in,
        output MEM_allow_in, MEM_to_WB_valid, to_WB_data, MEM_forward, MEM_load_blk
    );

    modport slave (
        output EX_to_MEM_valid, to_MEM_data, data_sram_data_ok, data_sram_rdata, WB_allow_in,
        input  MEM_allow_in, MEM_to_WB_valid, to_WB_data, MEM_forward, MEM_load_blk
    );

endinterface

// File: rtl/mem_load_align.sv
// Picks the addressed byte/halfword out of a loaded word and sign/zero-extends it.
// Purely combinational so it can be shared with a later misalignment check.
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_low,
    input  logic [2:0]  load_op,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        unique case (addr_low)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = addr_low[1] ? rdata[31:16] : rdata[15:0];

        result = rdata;
        case (load_op)
            LOAD_B:  result = {{24{byte_sel[7]}}, byte_sel};
            LOAD_BU: result = {24'd0, byte_sel};
            LOAD_H:  result = {{16{half_sel[15]}}, half_sel};
            LOAD_HU: result = {16'd0, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX->MEM register, data-SRAM response tracking, load extraction,
// MEM->WB handshake and the forwarding/load-stall signals towards ID.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    mem_stage_if.master bus
);

    logic        mem_valid_q, mem_valid_d;
    mem_state_e  state_q, state_d;
    logic [31:0] rdata_buf_q, rdata_buf_d;
    ex_mem_bus_t payload_q, payload_d;

    logic        ready_go;
    logic        allow_in;
    logic        accept;
    logic        wb_fire;
    logic        capture;
    logic [31:0] load_word;
    logic [31:0] extracted;
    logic [31:0] final_result;

    always_comb begin
        ready_go = 1'b1;
        if (state_q == MEM_WAIT) begin
            ready_go = bus.data_sram_data_ok;
        end
        allow_in = ~mem_valid_q | (ready_go & bus.WB_allow_in);
        accept   = bus.EX_to_MEM_valid & allow_in;
        wb_fire  = mem_valid_q & ready_go & bus.WB_allow_in;
        capture  = (state_q == MEM_WAIT) & bus.data_sram_data_ok & ~bus.WB_allow_in;
    end

    // A new instruction always reloads the FSM, even in the cycle the old one leaves.
    always_comb begin
        mem_valid_d = mem_valid_q;
        payload_d   = payload_q;
        state_d     = state_q;
        rdata_buf_d = rdata_buf_q;

        if (allow_in) begin
            mem_valid_d = bus.EX_to_MEM_valid;
        end

        if (accept) begin
            payload_d = bus.to_MEM_data;
            state_d   = bus.to_MEM_data[0] ? MEM_WAIT : MEM_EMPTY;
        end else if (wb_fire) begin
            state_d = MEM_EMPTY;
        end else if (capture) begin
            state_d = MEM_HAVE;
        end

        if (capture) begin
            rdata_buf_d = bus.data_sram_rdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_valid_q <= 1'b0;
            state_q     <= MEM_EMPTY;
            rdata_buf_q <= 32'd0;
            payload_q   <= '0;
        end else begin
            mem_valid_q <= mem_valid_d;
            state_q     <= state_d;
            rdata_buf_q <= rdata_buf_d;
            payload_q   <= payload_d;
        end
    end

    assign load_word = (state_q == MEM_HAVE) ? rdata_buf_q : bus.data_sram_rdata;

    mem_load_align u_align (
        .rdata    (load_word),
        .addr_low (payload_q.alu_result[1:0]),
        .load_op  (payload_q.load_op),
        .result   (extracted)
    );

    assign final_result = payload_q.res_from_mem ? extracted : payload_q.alu_result;

    assign bus.MEM_allow_in    = allow_in;
    assign bus.MEM_to_WB_valid = mem_valid_q & ready_go;
    assign bus.to_WB_data      = {payload_q.pc, payload_q.dest, final_result, payload_q.gr_we};
    assign bus.MEM_forward     = {payload_q.dest & {5{mem_valid_q & payload_q.gr_we}}, final_result};
    assign bus.MEM_load_blk    = mem_valid_q & payload_q.res_from_mem & ~ready_go;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios with literal expectations, then random
// traffic checked every cycle against an instruction-level model of the stage.
module tb_mem_stage;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   compared = 0;
    int   failed = 0;

    always #5 clk = ~clk;

    mem_stage_if bus();

    mem_stage dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    // Model: at most one instruction in MEM, plus whether its SRAM data already arrived.
    logic        m_valid = 1'b0;
    logic        m_got = 1'b0;
    logic [31:0] m_data = 32'd0;
    logic [74:0] m_ins = '0;
    logic        m_ready;
    logic        m_accept;
    logic        m_leave;

    logic [2:0] load_ops [5] = '{3'b000, 3'b001, 3'b101, 3'b010, 3'b110};

    function automatic logic [31:0] model_extract(input logic [31:0] w, input logic [1:0] a,
                                                  input logic [2:0] op);
        logic [31:0] v;
        int          sh;
        v = w;
        if (op == 3'b001 || op == 3'b101) begin
            sh = 8 * int'(a);
            v  = (w >> sh) & 32'h0000_00FF;
            if (op == 3'b001 && v >= 32'd128) v = v | 32'hFFFF_FF00;
        end else if (op == 3'b010 || op == 3'b110) begin
            sh = a[1] ? 16 : 0;
            v  = (w >> sh) & 32'h0000_FFFF;
            if (op == 3'b010 && v >= 32'd32768) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [74:0] mk_ex(input logic [31:0] pc, input logic [4:0] dest,
                                          input logic [31:0] alu, input logic gr_we,
                                          input logic rfm, input logic [2:0] op, input logic req);
        return {pc, dest, alu, gr_we, rfm, op, req};
    endfunction

    task automatic check_output(input string name, input logic [69:0] actual,
                                input logic [69:0] expected);
        compared = compared + 1;
        if (actual !== expected) begin
            failed = failed + 1;
            $display("[TB] FAIL %s: got %h, want %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic apply_stimulus(input logic ex_valid, input logic [74:0] ex_data,
                                  input logic ok, input logic [31:0] rdata, input logic wb_allow);
        @(posedge clk);
        #1;
        bus.EX_to_MEM_valid   = ex_valid;
        bus.to_MEM_data       = ex_data;
        bus.data_sram_data_ok = ok;
        bus.data_sram_rdata   = rdata;
        bus.WB_allow_in       = wb_allow;
    endtask

    function automatic logic model_ready();
        return !m_valid || !m_ins[0] || m_got || bus.data_sram_data_ok;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_valid = 1'b0;
            m_got   = 1'b0;
        end else begin
            m_ready  = model_ready();
            m_leave  = m_valid && m_ready && bus.WB_allow_in;
            m_accept = bus.EX_to_MEM_valid && (!m_valid || m_leave);
            if (m_accept) begin
                m_valid = 1'b1;
                m_ins   = bus.to_MEM_data;
                m_got   = 1'b0;
            end else if (m_leave) begin
                m_valid = 1'b0;
            end else if (m_valid && m_ins[0] && !m_got && bus.data_sram_data_ok) begin
                m_got  = 1'b1;
                m_data = bus.data_sram_rdata;
            end
        end
    end

    logic        c_ready;
    logic [31:0] c_result;
    always @(negedge clk) begin
        c_ready = model_ready();
        check_output("model_allow_in", 70'(bus.MEM_allow_in),
                     70'(!m_valid || (c_ready && bus.WB_allow_in)));
        check_output("model_wb_valid", 70'(bus.MEM_to_WB_valid), 70'(m_valid && c_ready));
        check_output("model_load_blk", 70'(bus.MEM_load_blk), 70'(m_valid && m_ins[4] && !c_ready));
        if (m_valid) begin
            c_result = m_ins[4] ? model_extract(m_got ? m_data : bus.data_sram_rdata,
                                                m_ins[7:6], m_ins[3:1])
                                : m_ins[37:6];
            check_output("model_forward", 70'(bus.MEM_forward),
                         70'({m_ins[5] ? m_ins[42:38] : 5'd0, c_result}));
            if (c_ready) begin
                check_output("model_to_wb", bus.to_WB_data,
                             {m_ins[74:43], m_ins[42:38], c_result, m_ins[5]});
            end
        end
    end

    task automatic run_load(input logic [2:0] op, input logic [31:0] alu, input logic [31:0] want);
        apply_stimulus(1'b1, mk_ex(32'h1C000100, 5'd9, alu, 1'b1, 1'b1, op, 1'b1), 1'b0, 32'd0, 1'b1);
        apply_stimulus(1'b0, '0, 1'b0, 32'd0, 1'b1);
        @(negedge clk);
        check_output("ld_blk_c1", 70'(bus.MEM_load_blk), 70'd1);
        apply_stimulus(1'b0, '0, 1'b0, 32'd0, 1'b1);
        @(negedge clk);
        check_output("ld_blk_c2", 70'(bus.MEM_load_blk), 70'd1);
        apply_stimulus(1'b0, '0, 1'b1, 32'h80FF7F01, 1'b1);
        @(negedge clk);
        check_output("ld_valid", 70'(bus.MEM_to_WB_valid), 70'd1);
        check_output("ld_blk_done", 70'(bus.MEM_load_blk), 70'd0);
        check_output("ld_result", 70'(bus.to_WB_data[32:1]), 70'(want));
    endtask

    initial begin
        logic [74:0] rnd_ex;
        logic        req;
        logic        is_ld;

        bus.EX_to_MEM_valid   = 1'b0;
        bus.to_MEM_data       = '0;
        bus.data_sram_data_ok = 1'b0;
        bus.data_sram_rdata   = 32'd0;
        bus.WB_allow_in       = 1'b1;

        @(negedge clk);
        check_output("rst_wb_valid", 70'(bus.MEM_to_WB_valid), 70'd0);
        check_output("rst_allow_in", 70'(bus.MEM_allow_in), 70'd1);
        check_output("rst_forward", 70'(bus.MEM_forward), 70'd0);
        check_output("rst_load_blk", 70'(bus.MEM_load_blk), 70'd0);
        check_output("rst_to_wb", bus.to_WB_data, 70'd0);
        @(negedge clk);
        resetn = 1'b1;

        apply_stimulus(1'b1, mk_ex(32'h1C000010, 5'd5, 32'h12345678, 1'b1, 1'b0, 3'b000, 1'b0),
                       1'b0, 32'd0, 1'b1);
        @(negedge clk);
        check_output("alu_allow_in", 70'(bus.MEM_allow_in), 70'd1);
        apply_stimulus(1'b0, '0, 1'b0, 32'd0, 1'b1);
        @(negedge clk);
        check_output("alu_wb_valid", 70'(bus.MEM_to_WB_valid), 70'd1);
        check_output("alu_to_wb", bus.to_WB_data, {32'h1C000010, 5'd5, 32'h12345678, 1'b1});
        check_output("alu_forward", 70'(bus.MEM_forward), 70'({5'd5, 32'h12345678}));

        run_load(3'b001, 32'h00001003, 32'hFFFFFF80);
        run_load(3'b101, 32'h00001003, 32'h00000080);
        run_load(3'b010, 32'h00001002, 32'hFFFF80FF);
        run_load(3'b110, 32'h00001002, 32'h000080FF);

        // ld.w whose data arrives while WB is stalled; SRAM bus changes afterwards
        apply_stimulus(1'b1, mk_ex(32'h1C000200, 5'd3, 32'h00002000, 1'b1, 1'b1, 3'b000, 1'b1),
                       1'b0, 32'd0, 1'b1);
        apply_stimulus(1'b0, '0, 1'b1, 32'hDEADBEEF, 1'b0);
        @(negedge clk);
        check_output("buf_allow_c0", 70'(bus.MEM_allow_in), 70'd0);
        check_output("buf_result_c0", 70'(bus.to_WB_data[32:1]), 70'h0DEADBEEF);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b0, '0, 1'b0, 32'h11111111 * (i + 1), 1'b0);
            @(negedge clk);
            check_output("buf_allow_hold", 70'(bus.MEM_allow_in), 70'd0);
            check_output("buf_valid_hold", 70'(bus.MEM_to_WB_valid), 70'd1);
            check_output("buf_result_hold", 70'(bus.to_WB_data[32:1]), 70'h0DEADBEEF);
        end
        apply_stimulus(1'b0, '0, 1'b0, 32'h55555555, 1'b1);
        @(negedge clk);
        check_output("buf_allow_go", 70'(bus.MEM_allow_in), 70'd1);
        check_output("buf_result_go", 70'(bus.to_WB_data[32:1]), 70'h0DEADBEEF);

        // back-to-back ld.w / add / st.w, each completing in its first MEM cycle
        apply_stimulus(1'b1, mk_ex(32'h1C000300, 5'd4, 32'h00003000, 1'b1, 1'b1, 3'b000, 1'b1),
                       1'b0, 32'd0, 1'b1);
        apply_stimulus(1'b1, mk_ex(32'h1C000304, 5'd6, 32'h00000042, 1'b1, 1'b0, 3'b000, 1'b0),
                       1'b1, 32'hCAFEF00D, 1'b1);
        @(negedge clk);
        check_output("b2b_ld_valid", 70'(bus.MEM_to_WB_valid), 70'd1);
        check_output("b2b_ld_result", 70'(bus.to_WB_data[32:1]), 70'h0CAFEF00D);
        apply_stimulus(1'b1, mk_ex(32'h1C000308, 5'd7, 32'h00003004, 1'b0, 1'b0, 3'b000, 1'b1),
                       1'b0, 32'd0, 1'b1);
        @(negedge clk);
        check_output("b2b_add_valid", 70'(bus.MEM_to_WB_valid), 70'd1);
        check_output("b2b_add_result", 70'(bus.to_WB_data[32:1]), 70'h000000042);
        apply_stimulus(1'b0, '0, 1'b1, 32'h0, 1'b1);
        @(negedge clk);
        check_output("b2b_st_valid", 70'(bus.MEM_to_WB_valid), 70'd1);
        check_output("b2b_st_gr_we", 70'(bus.to_WB_data[0]), 70'd0);
        check_output("b2b_st_fwd_dest", 70'(bus.MEM_forward[36:32]), 70'd0);

        // reset while waiting, then a stray data_ok
        apply_stimulus(1'b1, mk_ex(32'h1C000400, 5'd8, 32'h00004000, 1'b1, 1'b1, 3'b000, 1'b1),
                       1'b0, 32'd0, 1'b1);
        apply_stimulus(1'b0, '0, 1'b0, 32'd0, 1'b1);
        @(negedge clk);
        check_output("rw_load_blk", 70'(bus.MEM_load_blk), 70'd1);
        #2 resetn = 1'b0;
        #1;
        check_output("rw_wb_valid", 70'(bus.MEM_to_WB_valid), 70'd0);
        check_output("rw_allow_in", 70'(bus.MEM_allow_in), 70'd1);
        check_output("rw_forward", 70'(bus.MEM_forward), 70'd0);
        check_output("rw_load_blk0", 70'(bus.MEM_load_blk), 70'd0);
        check_output("rw_to_wb", bus.to_WB_data, 70'd0);
        @(negedge clk);
        resetn = 1'b1;
        apply_stimulus(1'b0, '0, 1'b1, 32'h5A5A5A5A, 1'b1);
        @(negedge clk);
        check_output("stray_ok_valid", 70'(bus.MEM_to_WB_valid), 70'd0);

        for (int i = 0; i < 800; i++) begin
            req    = 1'($urandom_range(0, 1));
            is_ld  = req && ($urandom_range(0, 2) != 0);
            rnd_ex = mk_ex($urandom, 5'($urandom), $urandom,
                           is_ld ? 1'b1 : (req ? 1'b0 : 1'($urandom_range(0, 1))),
                           is_ld, is_ld ? load_ops[$urandom_range(0, 4)] : 3'b000, req);
            apply_stimulus(1'($urandom_range(0, 3) != 0), rnd_ex, 1'($urandom_range(0, 9) < 4),
                           $urandom, 1'($urandom_range(0, 9) < 7));
            if (i == 400) begin
                #2 resetn = 1'b0;
                @(negedge clk);
                resetn = 1'b1;
            end
        end

        apply_stimulus(1'b0, '0, 1'b0, 32'd0, 1'b1);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
